// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between two requesters. Ownership alternates round-robin, and an owner holding
// the RAM is forced to hand over after MAX_BURST accesses if the other side waits.
// Ports:
//   clk, rst                        clock, async active-high reset
//   req/we/addr/wdata{0,1}          per-requester access request (held until ack)
//   ack{0,1}                        access accepted this cycle (combinational)
//   rvalid{0,1}, rdata{0,1}         read return, one cycle after an accepted read
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   RAM side
//   owner                           one-hot current owner {1,0}, 2'b00 when idle
module ram_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              last, last_next;
  logic [CNT_W-1:0]  cnt, cnt_next;

  // Current owner's request fields, selected once so both OWN states share logic.
  logic              sel;
  logic              own_req, oth_req, own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  assign sel       = (state == OWN1);
  assign own_req   = sel ? req1   : req0;
  assign oth_req   = sel ? req0   : req1;
  assign own_we    = sel ? we1    : we0;
  assign own_addr  = sel ? addr1  : addr0;
  assign own_wdata = sel ? wdata1 : wdata0;

  // State, last owner, burst count and read-return strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_next;
      last    <= last_next;
      cnt     <= cnt_next;
      rvalid0 <= (state == OWN0) & req0 & ~we0;
      rvalid1 <= (state == OWN1) & req1 & ~we1;
    end
  end

  // Next state, burst accounting and RAM/ack drive.
  always_comb begin
    state_next = state;
    last_next  = last;
    cnt_next   = cnt;
    ack0       = 1'b0;
    ack1       = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    owner      = 2'b00;
    case (state)
      IDLE: begin
        // On contention the side that did not own last wins.
        if (req0 && (!req1 || last)) begin
          state_next = OWN0;
          last_next  = 1'b0;
        end else if (req1) begin
          state_next = OWN1;
          last_next  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        ack0      = ~sel & req0;
        ack1      = sel & req1;
        ram_en    = own_req;
        ram_we    = own_req & own_we;
        ram_addr  = own_req ? own_addr  : '0;
        ram_wdata = own_req ? own_wdata : '0;
        owner     = sel ? 2'b10 : 2'b01;
        if (!own_req) begin
          cnt_next = '0;
          if (oth_req) begin
            state_next = sel ? OWN0 : OWN1;
            last_next  = ~sel;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          // Burst exhausted: hand over only if the other side is waiting.
          cnt_next = '0;
          if (oth_req) begin
            state_next = sel ? OWN0 : OWN1;
            last_next  = ~sel;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rdata0 = rvalid0 ? ram_rdata : '0;
  assign rdata1 = rvalid1 ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter (MAX_BURST=4): directed stimulus pushes expected
// RAM accesses and read returns; a negedge monitor pops and compares them.
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } op_t;

  typedef struct packed {
    logic [1:0] owner;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [1:0] owner;

  logic [7:0] mem [256];

  op_t  op0_q[$], op1_q[$];
  acc_t exp_acc[$];
  rd_t  exp_rd[$];
  int   rd_cyc[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every RAM access and every read return is matched against the queues.
  initial begin
    acc_t e;
    rd_t  r;
    int   c;
    forever begin
      @(negedge clk);
      cyc++;
      if (ram_en) begin
        if (exp_acc.size() == 0) begin
          chk("unexpected_access", {ram_we, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_acc.pop_front();
          chk("access", {owner, ram_we, ram_addr, ram_wdata}, e);
          chk("acks", {ack1, ack0}, e.owner);
          if (!e.we) rd_cyc.push_back(cyc);
        end
        n_acc++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end else begin
        chk("acks_idle", {ack1, ack0}, 2'b00);
      end
      if (rvalid0 || rvalid1) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_rvalid", {rvalid1, rvalid0}, 2'b00);
        end else begin
          r = exp_rd.pop_front();
          chk("rvalid", {rvalid1, rvalid0}, r.port ? 2'b10 : 2'b01);
          chk("rdata", r.port ? rdata1 : rdata0, r.data);
          chk("rdata_other", r.port ? rdata0 : rdata1, 8'h00);
          c = (rd_cyc.size() > 0) ? rd_cyc.pop_front() : -100;
          chk("rvalid_latency", cyc - c, 1);
        end
      end else begin
        chk("rdata_idle", {rdata1, rdata0}, 16'h0000);
      end
    end
  end

  // Drives one requester through its op queue, holding each op until acked.
  task automatic drive(input bit k, output int first_wait);
    op_t o;
    int  w;
    bit  first = 1'b1;
    first_wait = -1;
    while ((k ? op1_q.size() : op0_q.size()) > 0) begin
      o = k ? op1_q.pop_front() : op0_q.pop_front();
      if (!k) begin req0 = 1'b1; we0 = o.we; addr0 = o.addr; wdata0 = o.wdata; end
      else    begin req1 = 1'b1; we1 = o.we; addr1 = o.addr; wdata1 = o.wdata; end
      w = 0;
      forever begin
        @(negedge clk);
        if (k ? ack1 : ack0) break;
        w++;
        if (w > 60) break;
      end
      if (w > 60) begin
        chk("ack_timeout", w, 0);
        break;
      end
      if (first) first_wait = w;
      first = 1'b0;
      @(posedge clk);
      #1;
    end
    if (!k) req0 = 1'b0;
    else    req1 = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain, then settle two cycles.
  task automatic drain(input string name);
    int n = 0;
    while ((exp_acc.size() + exp_rd.size()) > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_acc.size() + exp_rd.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_span();
    n_acc = 0;
    first_cyc = -1;
    last_cyc = -1;
  endtask

  initial begin
    int fw0, fw1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;

    // Reset state
    #1;
    chk("reset_outputs", {ack1, ack0, ram_en, ram_we, owner, rvalid1, rvalid0}, 8'h00);
    chk("reset_bus", {ram_addr, ram_wdata, rdata0, rdata1}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("idle_owner", owner, 2'b00);
    @(posedge clk); #1;

    // S1: requester 0 writes A0..A3 to 0..3 alone
    reset_span();
    for (int i = 0; i < 4; i++) begin
      op0_q.push_back('{1'b1, 8'(i), 8'(8'hA0 + i)});
      exp_acc.push_back('{2'b01, 1'b1, 8'(i), 8'(8'hA0 + i)});
    end
    drive(1'b0, fw0);
    chk("s1_ack0_latency", fw0, 1);
    drain("s1_drain");
    chk("s1_span", last_cyc - first_cyc + 1, 4);

    // S3: requester 1 reads 0x10 (0x5A)
    op1_q.push_back('{1'b0, 8'h10, 8'hEE});
    exp_acc.push_back('{2'b10, 1'b0, 8'h10, 8'hEE});
    exp_rd.push_back('{1'b1, 8'h5A});
    drive(1'b1, fw1);
    chk("s3_ack1_latency", fw1, 1);
    drain("s3_drain");

    // S5: req0 drops after 2 accesses while req1 waits; req0 read returns during handover
    reset_span();
    op0_q.push_back('{1'b1, 8'h05, 8'hD5});
    op0_q.push_back('{1'b0, 8'h00, 8'hEE});
    op1_q.push_back('{1'b0, 8'h01, 8'hEE});
    exp_acc.push_back('{2'b01, 1'b1, 8'h05, 8'hD5});
    exp_acc.push_back('{2'b01, 1'b0, 8'h00, 8'hEE});
    exp_acc.push_back('{2'b10, 1'b0, 8'h01, 8'hEE});
    exp_rd.push_back('{1'b0, 8'hA0});
    exp_rd.push_back('{1'b1, 8'hA1});
    fork
      drive(1'b0, fw0);
      drive(1'b1, fw1);
    join
    chk("s5_ack0_latency", fw0, 1);
    chk("s5_ack1_wait", fw1, 4);
    drain("s5_drain");
    chk("s5_span", last_cyc - first_cyc + 1, 4);
    chk("s5_mem_write", mem[8'h05], 8'hD5);

    // S6: async reset while a read return is in flight
    exp_acc.push_back('{2'b01, 1'b0, 8'h02, 8'hEE});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h02; wdata0 = 8'hEE;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("s6_pre_reset", {rvalid0, ack0, ram_en}, 3'b111);
    rst = 1'b1;
    #1;
    chk("s6_reset_drop", {rvalid1, rvalid0, ack1, ack0, ram_en, owner}, 7'b0);
    chk("s6_reset_rdata", rdata0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b0;
    rd_cyc.delete();
    chk("s6_after_release", {owner, ram_en, rvalid0}, 4'b0);
    @(posedge clk); #1;
    chk("s6_scoreboard", exp_acc.size(), 0);

    // S2: both requesting after reset, burst limit 4 -> 01 x4, 10 x4, 01 x4
    reset_span();
    for (int i = 0; i < 8; i++) op0_q.push_back('{1'b1, 8'(8'h20 + i), 8'(8'hB0 + i)});
    for (int i = 0; i < 4; i++) op1_q.push_back('{1'b1, 8'(8'h30 + i), 8'(8'hC0 + i)});
    for (int i = 0; i < 4; i++) exp_acc.push_back('{2'b01, 1'b1, 8'(8'h20 + i), 8'(8'hB0 + i)});
    for (int i = 0; i < 4; i++) exp_acc.push_back('{2'b10, 1'b1, 8'(8'h30 + i), 8'(8'hC0 + i)});
    for (int i = 4; i < 8; i++) exp_acc.push_back('{2'b01, 1'b1, 8'(8'h20 + i), 8'(8'hB0 + i)});
    fork
      drive(1'b0, fw0);
      drive(1'b1, fw1);
    join
    chk("s2_ack0_latency", fw0, 1);
    chk("s2_ack1_wait", fw1, 5);
    drain("s2_drain");
    chk("s2_n_acc", n_acc, 12);
    chk("s2_no_gap", last_cyc - first_cyc + 1, 12);

    // S4: req0 alone for 20 accesses, burst limit never forces a gap
    reset_span();
    for (int i = 0; i < 20; i++) begin
      op0_q.push_back('{1'b1, 8'(8'h40 + i), 8'(i)});
      exp_acc.push_back('{2'b01, 1'b1, 8'(8'h40 + i), 8'(i)});
    end
    drive(1'b0, fw0);
    drain("s4_drain");
    chk("s4_no_gap", last_cyc - first_cyc + 1, 20);
    chk("s4_mem_last", mem[8'h53], 8'h13);

    chk("final_acc_queue", exp_acc.size(), 0);
    chk("final_rd_queue", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares one single-port synchronous RAM (1-cycle read latency) between two requesters, e.g. a fill engine and a slow readout engine. Round-robin ownership with a burst limit: the owner keeps the RAM for back-to-back accesses until it releases or has used MAX_BURST accesses while the other side waits. Per-requester valid/ack handshake on the request side and a read-return strobe on the response side.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
MAX_BURST, 16, max consecutive accepted accesses before a forced handover when the other side requests; legal range 1..255

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 access request, held until acked
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  requester 0 access accepted this cycle
rvalid0  out  1  requester 0 read data valid
rdata0  out  DATA_W  requester 0 read data
req1, we1, addr1, wdata1, ack1, rvalid1, rdata1  same as above for requester 1
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read access
owner  out  2  one-hot current owner {1,0}; 2'b00 when idle

Behaviour:
- FSM states IDLE, OWN0, OWN1. Registered: state, last (last owner, 1 bit), cnt (8 bit burst count), rvalid0/1.
- Reset (async, immediate): state=IDLE, last=1 (requester 0 favoured first), cnt=0, rvalid0/1=0. Hence ack0/1=0, ram_en=ram_we=0, ram_addr=0, ram_wdata=0, owner=00. An in-flight read is dropped: no rvalid after reset.
- IDLE: no acks, RAM outputs zero. At edge: only reqk -> OWNk; both -> OWN(~last). Arbitration costs exactly one cycle from IDLE.
- OWNk: ackk = reqk (combinational); ack of the other side = 0. ram_en=reqk; ram_we=reqk&wek; ram_addr/ram_wdata = addrk/wdatak when reqk, else 0. owner=one-hot k. last<=k when entering OWNk.
- Accepted access = reqk & ackk. cnt increments on each accepted access.
- OWNk transitions at edge, priority order:
  1. reqk=0: -> OWN(other) if other req=1, else IDLE; cnt<=0.
  2. accepted access and cnt==MAX_BURST-1: if other req=1 -> OWN(other), cnt<=0; else stay, cnt<=0.
  3. otherwise stay.
- Handover between owners costs no idle cycle: the new owner is acked on the first cycle after the edge.
- Read return: rvalidk <= accepted & ~wek & owner k, i.e. high exactly 1 cycle after the accepted read, for 1 cycle per read. rdatak = ram_rdata when rvalidk, else 0 (combinational). Back-to-back reads give back-to-back rvalid.
- A requester must hold req/we/addr/wdata stable until acked; the arbiter does not buffer requests.
- Address/data pass straight through, no width conversion; no wrap logic (the requester owns address sequencing).

Test Plan:
- Reset, req0=1 writes addr 0..3, data 0xA0..0xA3, req1=0 -> ack0 first high 1 cycle after req0; ram_we high 4 cycles with ram_addr 0,1,2,3 and ram_wdata A0..A3; owner=01; ack1 never high.
- MAX_BURST=4, req0 and req1 both continuously high from reset -> owner 01 for 4 acked accesses, then 10 for 4, then 01; no cycle with ram_en=0 after the first arbitration cycle.
- RAM model holds 0x5A at 0x10; requester 1 reads 0x10 -> rvalid1=1 exactly 1 cycle after the ack1 cycle, rdata1=0x5A; rvalid0=0, rdata0=0.
- req0 alone for 20 accesses with MAX_BURST=16 -> 20 consecutive ack0 cycles with no gap; cnt rolls to 0 after the 16th access.
- MAX_BURST=16, req0 drops after 2 accepted accesses while req1=1 -> the next cycle has owner=10 and ack1=1; rvalid of any outstanding requester-0 read is still delivered to rvalid0.
- rst asserted asynchronously in the cycle after an accepted read -> rvalid0/1, ack0/1 and ram_en drop immediately; after release state=IDLE; with both requesting, requester 0 wins first.
